// File: rtl/rv32_pkg.sv
// Shared rv32 control definitions: opcodes, sequencer states, instruction
// classes and datapath select encodings.
package rv32_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      S_RST, FETCH, DECODE, EXEC, MEM, WB, ERR
   } state_t;

   typedef enum logic [3:0] {
      CL_R, CL_IMM, CL_LOAD, CL_STORE, CL_BRANCH,
      CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILLEGAL
   } instr_class_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00, ALU_BRANCH = 2'b01, ALU_RFUNCT = 2'b10, ALU_IFUNCT = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      SRC_A_RS1 = 2'b00, SRC_A_PC = 2'b01, SRC_A_ZERO = 2'b10
   } alu_src_a_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10
   } mem_to_reg_t;

   function automatic logic is_mem(instr_class_t c);
      return (c == CL_LOAD) || (c == CL_STORE);
   endfunction

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode-to-class decoder, shared by the sequencer and ALU control.
module opcode_class
   import rv32_pkg::*;
(
   input  logic [6:0]   opcode_i,
   input  logic [2:0]   func3_i,
   output instr_class_t class_o
);

   always_comb begin
      class_o = CL_ILLEGAL;
      case (opcode_i)
         OP_R:      class_o = CL_R;
         OP_IMM:    class_o = CL_IMM;
         // Loads/stores are only legal with a defined access width.
         OP_LOAD:   if (func3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) class_o = CL_LOAD;
         OP_STORE:  if (func3_i inside {3'b000, 3'b001, 3'b010}) class_o = CL_STORE;
         OP_BRANCH: class_o = CL_BRANCH;
         OP_JAL:    class_o = CL_JAL;
         OP_JALR:   class_o = CL_JALR;
         OP_LUI:    class_o = CL_LUI;
         OP_AUIPC:  class_o = CL_AUIPC;
         default:   class_o = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle rv32 control sequencer with req/ready memory handshakes and timeout.
// Define MC_SEQ_TRAP_ILLEGAL_EN to trap illegal opcodes into ERR with a sticky flag.
module mc_sequencer
   import rv32_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   input  logic       branch_taken,
   output logic       imem_req,
   output logic       ir_write,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic       alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] mem_to_reg,
   output logic       instr_retire,
   output logic       bus_err,
   output logic       illegal
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

   state_t             state_q;
   instr_class_t       cls_q;
   instr_class_t       dec_cls;
   logic [CNT_W-1:0]   cnt_q;
   logic               bus_err_q;
   logic               dec_illegal;
   logic               timeout;
`ifdef MC_SEQ_TRAP_ILLEGAL_EN
   logic               illegal_q;
`endif

   opcode_class u_opcode_class (
      .opcode_i (opcode),
      .func3_i  (func3),
      .class_o  (dec_cls)
   );

   assign dec_illegal = (dec_cls == CL_ILLEGAL);
   assign timeout     = (cnt_q == TIMEOUT_CNT);
   assign bus_err     = bus_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_RST;
         cls_q     <= CL_ILLEGAL;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
`ifdef MC_SEQ_TRAP_ILLEGAL_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_RST: begin
               state_q <= FETCH;
               cnt_q   <= '0;
            end
            FETCH: begin
               // Ready on the final counted cycle still wins over the timeout.
               if (imem_ready) begin
                  state_q <= DECODE;
               end else if (timeout) begin
                  state_q   <= ERR;
                  bus_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DECODE: begin
               cls_q <= dec_cls;
               if (dec_illegal) begin
`ifdef MC_SEQ_TRAP_ILLEGAL_EN
                  state_q   <= ERR;
                  illegal_q <= 1'b1;
`else
                  state_q <= FETCH;
                  cnt_q   <= '0;
`endif
               end else begin
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               cnt_q <= '0;
               if (is_mem(cls_q))          state_q <= MEM;
               else if (cls_q == CL_BRANCH) state_q <= FETCH;
               else                         state_q <= WB;
            end
            MEM: begin
               if (dmem_ready) begin
                  cnt_q   <= '0;
                  state_q <= (cls_q == CL_STORE) ? FETCH : WB;
               end else if (timeout) begin
                  state_q   <= ERR;
                  bus_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WB: begin
               state_q <= FETCH;
               cnt_q   <= '0;
            end
            ERR:     state_q <= ERR;
            default: state_q <= ERR;
         endcase
      end
   end

   always_comb begin
      imem_req     = 1'b0;
      ir_write     = 1'b0;
      pc_inc       = 1'b0;
      pc_load      = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      reg_write    = 1'b0;
      alu_src_a    = SRC_A_RS1;
      alu_src_b    = 1'b0;
      alu_op       = ALU_ADD;
      mem_to_reg   = WB_ALU;
      instr_retire = 1'b0;
      illegal      = 1'b0;
      case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            ir_write = imem_ready;
            pc_inc   = imem_ready;
         end
         DECODE: begin
            illegal = dec_illegal;
`ifndef MC_SEQ_TRAP_ILLEGAL_EN
            instr_retire = dec_illegal;
`endif
         end
         EXEC, MEM: begin
            // Selects stay identical across EXEC and MEM for loads/stores.
            alu_src_b = 1'b1;
            case (cls_q)
               CL_R:             begin alu_src_b = 1'b0; alu_op = ALU_RFUNCT; end
               CL_IMM:           alu_op = ALU_IFUNCT;
               CL_BRANCH:        begin alu_src_b = 1'b0; alu_op = ALU_BRANCH; end
               CL_JAL, CL_AUIPC: alu_src_a = SRC_A_PC;
               CL_LUI:           alu_src_a = SRC_A_ZERO;
               default:          ;
            endcase
            if (state_q == EXEC) begin
               pc_load      = (cls_q == CL_BRANCH) ? branch_taken
                                                   : ((cls_q == CL_JAL) || (cls_q == CL_JALR));
               instr_retire = (cls_q == CL_BRANCH);
            end else begin
               dmem_req     = 1'b1;
               dmem_we      = (cls_q == CL_STORE);
               instr_retire = (cls_q == CL_STORE) && dmem_ready;
            end
         end
         WB: begin
            reg_write    = 1'b1;
            instr_retire = 1'b1;
            if (cls_q == CL_LOAD)                           mem_to_reg = WB_MEM;
            else if ((cls_q == CL_JAL) || (cls_q == CL_JALR)) mem_to_reg = WB_PC4;
         end
         default: ;
      endcase
`ifdef MC_SEQ_TRAP_ILLEGAL_EN
      illegal = illegal | illegal_q;
`endif
   end

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: per-instruction expected cycle traces.
module tb_mc_sequencer;

   localparam int unsigned TO = 4;

   localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4,
                  C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

   typedef struct packed {
      logic       imem_req, ir_write, pc_inc, pc_load, dmem_req, dmem_we, reg_write;
      logic [1:0] src_a;
      logic       src_b;
      logic [1:0] op;
      logic [1:0] m2r;
      logic       retire, bus_err, illegal;
   } outs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [6:0] opcode = '0;
   logic [2:0] func3 = '0;
   logic imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
   logic imem_req, ir_write, pc_inc, pc_load, dmem_req, dmem_we, reg_write;
   logic [1:0] alu_src_a, alu_op, mem_to_reg;
   logic alu_src_b, instr_retire, bus_err, illegal;
   outs_t act;
   int n_assert = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mc_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
      .imem_req(imem_req), .ir_write(ir_write), .pc_inc(pc_inc), .pc_load(pc_load),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .mem_to_reg(mem_to_reg), .instr_retire(instr_retire), .bus_err(bus_err),
      .illegal(illegal)
   );

   assign act = {imem_req, ir_write, pc_inc, pc_load, dmem_req, dmem_we, reg_write,
                 alu_src_a, alu_src_b, alu_op, mem_to_reg, instr_retire, bus_err, illegal};

   function automatic logic r1();
      return 1'($urandom);
   endfunction
   function automatic logic [2:0] r3();
      return 3'($urandom);
   endfunction
   function automatic logic [6:0] r7();
      return 7'($urandom);
   endfunction

   function automatic int cls_of(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b0000011: return (f3 == 3'd3 || f3 > 3'd5) ? C_ILL : C_LD;
         7'b0100011: return (f3 > 3'd2) ? C_ILL : C_ST;
         7'b1100011: return C_BR;
         7'b1101111: return C_JAL;
         7'b1100111: return C_JALR;
         7'b0110111: return C_LUI;
         7'b0010111: return C_AUIPC;
         default:    return C_ILL;
      endcase
   endfunction

   // Operand/ALU selects expected while the instruction is in EXEC (and MEM).
   function automatic outs_t alu_sel(input int c);
      outs_t e = '0;
      case (c)
         C_R:     begin e.src_a = 2'b00; e.src_b = 1'b0; e.op = 2'b10; end
         C_I:     begin e.src_a = 2'b00; e.src_b = 1'b1; e.op = 2'b11; end
         C_LD:    begin e.src_a = 2'b00; e.src_b = 1'b1; e.op = 2'b00; end
         C_ST:    begin e.src_a = 2'b00; e.src_b = 1'b1; e.op = 2'b00; end
         C_BR:    begin e.src_a = 2'b00; e.src_b = 1'b0; e.op = 2'b01; end
         C_JAL:   begin e.src_a = 2'b01; e.src_b = 1'b1; e.op = 2'b00; end
         C_JALR:  begin e.src_a = 2'b00; e.src_b = 1'b1; e.op = 2'b00; end
         C_LUI:   begin e.src_a = 2'b10; e.src_b = 1'b1; e.op = 2'b00; end
         C_AUIPC: begin e.src_a = 2'b01; e.src_b = 1'b1; e.op = 2'b00; end
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic step(input outs_t e, input logic ir, input logic dr, input logic bt,
                       input logic [6:0] op, input logic [2:0] f3, input string tag);
      imem_ready   = ir;
      dmem_ready   = dr;
      branch_taken = bt;
      opcode       = op;
      func3        = f3;
      @(negedge clk);
      n_assert++;
      assert (act === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, act, e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      step('0, r1(), r1(), r1(), r7(), r3(), "reset_hold");
      rst = 1'b0;
      step('0, r1(), r1(), r1(), r7(), r3(), "s_rst");
   endtask

   task automatic err_cycles(input logic be, input logic il, input int unsigned n);
      outs_t e = '0;
      e.bus_err = be;
      e.illegal = il;
      for (int unsigned k = 0; k < n; k++)
         step(e, r1(), r1(), r1(), r7(), r3(), "err_hold");
   endtask

   // di/dd: ready delay in cycles; a delay beyond TO means ready never comes.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                            input int unsigned di, input int unsigned dd,
                            input logic bt, input int abort_at);
      int c;
      outs_t e;
      int unsigned last;
      c = cls_of(op, f3);
      last = (di > TO) ? TO : di;
      for (int unsigned k = 0; k <= last; k++) begin
         e = '0;
         e.imem_req = 1'b1;
         e.ir_write = (k == di);
         e.pc_inc   = (k == di);
         step(e, k == di, r1(), r1(), r7(), r3(), "fetch");
      end
      if (di > TO) begin
         err_cycles(1'b1, 1'b0, 3);
         do_reset();
         return;
      end
      e = '0;
      e.illegal = (c == C_ILL);
`ifndef MC_SEQ_TRAP_ILLEGAL_EN
      e.retire = (c == C_ILL);
`endif
      step(e, r1(), r1(), r1(), op, f3, "decode");
      if (c == C_ILL) begin
`ifdef MC_SEQ_TRAP_ILLEGAL_EN
         err_cycles(1'b0, 1'b1, 3);
         do_reset();
`endif
         return;
      end
      e = alu_sel(c);
      e.pc_load = (c == C_BR) ? bt : (c == C_JAL || c == C_JALR);
      e.retire  = (c == C_BR);
      step(e, r1(), r1(), bt, r7(), r3(), "exec");
      if (c == C_BR) return;
      if (c == C_LD || c == C_ST) begin
         last = (dd > TO) ? TO : dd;
         for (int unsigned k = 0; k <= last; k++) begin
            e = alu_sel(c);
            e.dmem_req = 1'b1;
            e.dmem_we  = (c == C_ST);
            e.retire   = (c == C_ST) && (k == dd);
            if (abort_at >= 0 && k == unsigned'(abort_at)) begin
               rst = 1'b1;
               step(e, r1(), 1'b0, r1(), r7(), r3(), "mem_abort");
               rst = 1'b0;
               step('0, r1(), r1(), r1(), r7(), r3(), "abort_s_rst");
               return;
            end
            step(e, r1(), k == dd, r1(), r7(), r3(), "mem");
         end
         if (dd > TO) begin
            err_cycles(1'b1, 1'b0, 3);
            do_reset();
            return;
         end
         if (c == C_ST) return;
      end
      e = '0;
      e.reg_write = 1'b1;
      e.retire    = 1'b1;
      e.m2r = (c == C_LD) ? 2'b01 : ((c == C_JAL || c == C_JALR) ? 2'b10 : 2'b00);
      step(e, r1(), r1(), r1(), r7(), r3(), "wb");
   endtask

   initial begin
      logic [6:0] ops [9];
      logic [2:0] ld_f3 [5];
      int unsigned idx;
      logic [6:0] op;
      logic [2:0] f3;
      int unsigned di, dd;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
      ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      @(posedge clk);
      #1;
      do_reset();

      run_instr(7'b0110011, 3'd0, 0, 0, 1'b0, -1);        // R add
      run_instr(7'b0000011, 3'd2, 1, 3, 1'b0, -1);        // lw, dmem late
      run_instr(7'b0100011, 3'd2, 0, 1, 1'b0, -1);        // sw
      run_instr(7'b1100011, 3'd0, 0, 0, 1'b1, -1);        // beq taken
      run_instr(7'b1100011, 3'd0, 2, 0, 1'b0, -1);        // beq not taken
      run_instr(7'b1111111, 3'd0, 0, 0, 1'b0, -1);        // illegal opcode
      run_instr(7'b0110011, 3'd0, TO, 0, 1'b0, -1);       // imem ready on last counted cycle
      run_instr(7'b0000011, 3'd2, 0, TO, 1'b0, -1);       // dmem ready on last counted cycle
      run_instr(7'b0010011, 3'd0, TO + 1, 0, 1'b0, -1);   // fetch timeout
      run_instr(7'b0000011, 3'd2, 0, TO + 1, 1'b0, -1);   // load timeout
      run_instr(7'b0000011, 3'd2, 0, 3, 1'b0, 2);         // reset mid-MEM
      run_instr(7'b1101111, 3'd0, 0, 0, 1'b0, -1);        // jal after abort

      for (int n = 0; n < 60; n++) begin
         idx = $urandom_range(0, 9);
         if (idx == 9) begin
            op = r7();
            while (cls_of(op, 3'd0) != C_ILL) op = r7();
            f3 = r3();
         end else begin
            op = ops[idx];
            if (idx == 2)      f3 = ld_f3[$urandom_range(0, 4)];
            else if (idx == 3) f3 = 3'($urandom_range(0, 2));
            else               f3 = r3();
         end
         di = ($urandom_range(0, 15) == 0) ? TO + 1 : $urandom_range(0, TO);
         dd = ($urandom_range(0, 15) == 0) ? TO + 1 : $urandom_range(0, TO);
         run_instr(op, f3, di, dd, r1(), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle control sequencer for the rv32 core.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Issues the per-state datapath control strobes and the mux selects for the ALU and register file.
- Handshakes with instruction and data memory using req/ready, guarded by a timeout counter.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles to wait for imem_ready or dmem_ready before flagging bus_err; legal range 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2**CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from the instruction register
- func3  in  3  instr[14:12]; used only to classify loads and stores
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- branch_taken  in  1  compare result from the ALU, valid in EXEC
- imem_req  out  1  instruction fetch request
- ir_write  out  1  latch the instruction register
- pc_inc  out  1  PC <= PC+4
- pc_load  out  1  PC <= ALU target
- dmem_req  out  1  data access request
- dmem_we  out  1  data access is a store
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00 rs1, 01 pc, 10 zero
- alu_src_b  out  1  0 rs2, 1 imm
- alu_op  out  2  00 add, 01 branch compare, 10 R-funct, 11 I-funct
- mem_to_reg  out  2  00 alu, 01 mem, 10 pc+4
- instr_retire  out  1  one-cycle pulse when an instruction completes
- bus_err  out  1  sticky memory timeout flag
- illegal  out  1  unknown opcode seen in DECODE (one-cycle pulse, or sticky when TRAP_ILLEGAL_EN is defined)

Behaviour:
- States: S_RST, FETCH, DECODE, EXEC, MEM, WB, ERR.
- Reset:
  - rst at a clock edge sets state to S_RST and clears the wait counter, bus_err and illegal.
  - In S_RST every output is 0; next state is FETCH.
- Output style: all outputs are Moore decodes of the registered state plus the inputs noted below. Outputs not listed for a state are 0.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_write=1 and pc_inc=1 in that same cycle; go to DECODE.
  - Otherwise the wait counter increments.
- DECODE (1 cycle): classify opcode.
  - Legal classes: R 0110011, I-arith 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111.
  - Any other opcode: illegal=1, then handled as a NOP and goes to FETCH with instr_retire=1.
  - Legal opcode: go to EXEC.
- EXEC (1 cycle):
  - R: a=rs1, b=rs2, op=10; go to WB.
  - I-arith: a=rs1, b=imm, op=11; go to WB.
  - load/store: a=rs1, b=imm, op=00; go to MEM.
  - branch: a=rs1, b=rs2, op=01. pc_load=branch_taken. instr_retire=1; go to FETCH.
    - Target add is done in the datapath; pc_load only strobes it.
  - jal: a=pc, b=imm, op=00, pc_load=1; go to WB.
  - jalr: a=rs1, b=imm, op=00, pc_load=1; go to WB.
  - lui: a=zero, b=imm, op=00; go to WB.
  - auipc: a=pc, b=imm, op=00; go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for stores. alu_src and op are held as in EXEC.
  - On dmem_ready: a store goes to FETCH with instr_retire=1; a load goes to WB.
- WB (1 cycle):
  - reg_write=1, instr_retire=1.
  - mem_to_reg: 01 for load, 10 for jal/jalr, 00 otherwise.
  - Go to FETCH.
- Class latch: the instruction class is registered in DECODE, so EXEC/MEM/WB do not depend on opcode holding stable.
- Wait counter:
  - Cleared on entry to FETCH and to MEM.
  - Counts cycles with req=1 and ready=0.
  - When the count equals MEM_TIMEOUT and ready=0, go to ERR. Ready in that same cycle wins: normal transition, no error.
- ERR: all outputs 0 except bus_err=1; remains in ERR until rst.
- Reset mid-operation: rst in any state aborts the access. imem_req/dmem_req are 0 from the following cycle; no retire pulse is issued.
- Spurious ready: imem_ready or dmem_ready outside the matching state is ignored.
- Register-file write rule: reg_write is never asserted in the same cycle as dmem_req.

Optional Feature:
- Macro: MC_SEQ_TRAP_ILLEGAL_EN.
- Defined:
  - An illegal opcode in DECODE goes to ERR instead of FETCH.
  - illegal is sticky (cleared only by rst); bus_err stays 0 for this cause.
  - No retire pulse.
- Not defined: illegal is a one-cycle pulse and the instruction retires as a NOP.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode localparams
  - state_t enum
  - instr-class enum
  - alu_op, alu_src_a and mem_to_reg encodings
- Natural sub-module: opcode_class, a combinational opcode-to-class decoder also reused by the ALU control unit.

Test Plan:
- R add (0110011), imem_ready on the first FETCH cycle:
  - FETCH cycle 1, DECODE 2, EXEC 3 with alu_op=10 and alu_src_b=0.
  - WB cycle 4 with reg_write=1, mem_to_reg=00, instr_retire=1; 4 cycles per instruction.
- lw (0000011, func3=010), dmem_ready delayed 3 cycles:
  - dmem_req=1 and dmem_we=0 for 4 cycles.
  - Then WB with mem_to_reg=01 and reg_write=1.
- sw (0100011): dmem_we=1 in MEM; on dmem_ready, retire and return to FETCH with no reg_write.
- beq, two cases:
  - branch_taken=1: pc_load=1 in EXEC, then FETCH.
  - branch_taken=0: pc_load=0; retire still pulses.
- MEM_TIMEOUT=4, imem_ready held 0:
  - ERR after count 4; bus_err=1 and imem_req=0.
  - Remains in ERR until rst; imem_ready arriving on the count-4 cycle avoids ERR.
- Opcode 1111111, run both builds:
  - Without the macro: one illegal pulse, retire, back to FETCH.
  - With MC_SEQ_TRAP_ILLEGAL_EN: ERR, sticky illegal.
- Reset mid-MEM: rst during a pending load; dmem_req=0 the next cycle, S_RST, then FETCH.
